// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one byte-wide uart_tx among N_REQ packet sources.
// A grant is held for a whole packet; an optional idle timeout revokes stalled grants.
module uart_tx_arbiter #(
    parameter int N_REQ        = 4,
    parameter int IDLE_TIMEOUT = 0
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [N_REQ-1:0]   i_req_valid,
    input  logic [8*N_REQ-1:0] i_req_data,
    input  logic [N_REQ-1:0]   i_req_last,
    output logic [N_REQ-1:0]   o_req_ready,
    output logic [7:0]         o_tx_data,
    output logic               o_tx_valid,
    input  logic               i_tx_ready,
    output logic [N_REQ-1:0]   o_grant,
    output logic               o_busy,
    output logic [N_REQ-1:0]   o_timeout_err
);

    localparam int  IW     = $clog2(N_REQ);
    localparam int  CW     = (IDLE_TIMEOUT > 0) ? $clog2(IDLE_TIMEOUT + 1) : 1;
    localparam bit  TO_EN  = (IDLE_TIMEOUT > 0);
    localparam int  LIM_M1 = (IDLE_TIMEOUT > 0) ? IDLE_TIMEOUT - 1 : 0;

    typedef enum logic {S_IDLE, S_LOCKED} state_t;

    state_t           r_state, w_state_nxt;
    logic [N_REQ-1:0] r_grant, w_grant_nxt;
    logic [N_REQ-1:0] r_timeout_err, w_timeout_err_nxt;
    logic [IW-1:0]    r_last, w_last_nxt;
    logic [CW-1:0]    r_cnt, w_cnt_nxt;
    logic [IW-1:0]    w_gidx, w_win_idx;
    logic             w_win_found;
    logic             w_locked, w_gvalid, w_glast, w_xfer, w_timeout;
    logic [7:0]       w_gdata;

    always_comb begin
        w_gidx = '0;
        for (int i = 0; i < N_REQ; i++)
            if (r_grant[i]) w_gidx = IW'(i);
    end

    // Search starts just after the previous owner so nobody wins twice while others wait.
    always_comb begin
        int j;
        j           = 0;
        w_win_idx   = r_last;
        w_win_found = 1'b0;
        for (int k = 1; k <= N_REQ; k++) begin
            j = (int'(r_last) + k) % N_REQ;
            if (!w_win_found && i_req_valid[IW'(j)]) begin
                w_win_found = 1'b1;
                w_win_idx   = IW'(j);
            end
        end
    end

    assign w_locked  = (r_state == S_LOCKED);
    assign w_gvalid  = i_req_valid[w_gidx];
    assign w_glast   = i_req_last[w_gidx];
    assign w_gdata   = i_req_data[{w_gidx, 3'b000} +: 8];
    // Abort on the edge where the idle count reaches the limit; valid is low so nothing transfers.
    assign w_timeout = TO_EN && w_locked && !w_gvalid && (r_cnt >= CW'(LIM_M1));
    assign w_xfer    = o_tx_valid && i_tx_ready;

    assign o_tx_valid    = w_locked && w_gvalid;
    assign o_tx_data     = w_locked ? w_gdata : 8'h00;
    assign o_req_ready   = w_locked ? (r_grant & {N_REQ{i_tx_ready}}) : '0;
    assign o_grant       = r_grant;
    assign o_busy        = w_locked;
    assign o_timeout_err = r_timeout_err;

    always_comb begin
        w_state_nxt       = r_state;
        w_grant_nxt       = r_grant;
        w_last_nxt        = r_last;
        w_cnt_nxt         = r_cnt;
        w_timeout_err_nxt = '0;
        case (r_state)
            S_IDLE: begin
                w_cnt_nxt = '0;
                if (w_win_found) begin
                    w_state_nxt = S_LOCKED;
                    w_grant_nxt = {{(N_REQ-1){1'b0}}, 1'b1} << w_win_idx;
                end
            end
            S_LOCKED: begin
                if (w_gvalid)
                    w_cnt_nxt = '0;
                else if (r_cnt != {CW{1'b1}})
                    w_cnt_nxt = r_cnt + CW'(1);
                if (w_xfer && w_glast) begin
                    w_state_nxt = S_IDLE;
                    w_grant_nxt = '0;
                    w_last_nxt  = w_gidx;
                    w_cnt_nxt   = '0;
                end else if (w_timeout) begin
                    w_state_nxt       = S_IDLE;
                    w_grant_nxt       = '0;
                    w_last_nxt        = w_gidx;
                    w_cnt_nxt         = '0;
                    w_timeout_err_nxt = r_grant;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= S_IDLE;
            r_grant       <= '0;
            r_last        <= IW'(N_REQ - 1);
            r_cnt         <= '0;
            r_timeout_err <= '0;
        end else begin
            r_state       <= w_state_nxt;
            r_grant       <= w_grant_nxt;
            r_last        <= w_last_nxt;
            r_cnt         <= w_cnt_nxt;
            r_timeout_err <= w_timeout_err_nxt;
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: drivers feed per-requester byte queues,
// a negedge monitor pops expected {grant,byte} on every tx transfer.
module tb_uart_tx_arbiter;
    localparam int N = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  req_valid = '0, req_last = '0;
    logic [31:0] req_data = '0;
    logic [3:0]  req_ready, grant, timeout_err;
    logic [7:0]  tx_data;
    logic        tx_valid, tx_ready, busy;

    logic [8:0]  rq [N][$];
    logic [11:0] expq [$];
    logic [11:0] mon_e;
    logic [3:0]  hs_s = '0;
    logic        tx_hs_s = 1'b0;
    logic        tx_hold = 1'b0;
    int          tx_gap = 0, tx_busy = 0;
    int          n_pass = 0, n_tot = 0;

    always #5 clk = ~clk;
    assign tx_ready = !tx_hold && (tx_busy == 0);

    uart_tx_arbiter #(.N_REQ(N), .IDLE_TIMEOUT(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .i_req_valid(req_valid), .i_req_data(req_data), .i_req_last(req_last),
        .o_req_ready(req_ready), .o_tx_data(tx_data), .o_tx_valid(tx_valid),
        .i_tx_ready(tx_ready), .o_grant(grant), .o_busy(busy),
        .o_timeout_err(timeout_err)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
        n_tot++;
        if (act === exp_v) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp_v);
    endtask

    // Monitor: every tx transfer must match the head of the expected queue.
    always @(negedge clk) begin
        hs_s    = req_valid & req_ready;
        tx_hs_s = tx_valid & tx_ready;
        if (tx_valid && tx_ready) begin
            if (expq.size() == 0) begin
                n_tot++;
                $display("FAIL tx_unexpected: got byte %0h grant %b expected none", tx_data, grant);
            end else begin
                mon_e = expq.pop_front();
                chk("tx_data", tx_data, mon_e[7:0]);
                chk("tx_grant", grant, mon_e[11:8]);
            end
        end
    end

    // Requester drivers and uart_tx busy model (tx_ready low tx_gap cycles after each byte).
    always @(posedge clk) begin
        #1;
        for (int i = 0; i < N; i++) begin
            if (hs_s[i] && rq[i].size() > 0) rq[i].delete(0);
            if (rq[i].size() > 0) begin
                req_valid[i]         = 1'b1;
                req_last[i]          = rq[i][0][8];
                req_data[8*i +: 8]   = rq[i][0][7:0];
            end else begin
                req_valid[i]         = 1'b0;
                req_last[i]          = 1'b0;
                req_data[8*i +: 8]   = 8'h00;
            end
        end
        if (tx_hs_s) tx_busy = tx_gap;
        else if (tx_busy > 0) tx_busy--;
    end

    task automatic push(input int r, input logic last, input logic [7:0] d);
        rq[r].push_back({last, d});
    endtask

    task automatic expect_tx(input logic [3:0] g, input logic [7:0] d);
        expq.push_back({g, d});
    endtask

    function automatic bit rq_empty();
        bit e = 1'b1;
        for (int i = 0; i < N; i++) if (rq[i].size() != 0) e = 1'b0;
        return e;
    endfunction

    task automatic do_reset();
        rst_n = 1'b0;
        for (int i = 0; i < N; i++) rq[i].delete();
        expq.delete();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic wait_done(input string nm);
        int k = 0;
        while ((expq.size() != 0 || !rq_empty() || busy) && k < 3000) begin
            @(negedge clk);
            k++;
        end
        chk({nm, "_drain"}, expq.size(), 0);
        repeat (2) @(negedge clk);
    endtask

    initial begin
        int k, cnt, bad;
        #2;
        chk("rst_grant", grant, 0);
        chk("rst_busy", busy, 0);
        chk("rst_tx_valid", tx_valid, 0);
        chk("rst_req_ready", req_ready, 0);
        chk("rst_timeout_err", timeout_err, 0);
        chk("rst_tx_data", tx_data, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // 1: three-byte packet from requester 0 with a slow transmitter
        @(posedge clk); #1;
        tx_gap = 2;
        push(0, 0, 8'h41); push(0, 0, 8'h42); push(0, 1, 8'h43);
        expect_tx(4'b0001, 8'h41); expect_tx(4'b0001, 8'h42); expect_tx(4'b0001, 8'h43);
        wait_done("t1");
        chk("t1_busy_after", busy, 0);
        chk("t1_grant_after", grant, 0);

        // 2: all four post single-byte packets at once after reset
        do_reset();
        @(posedge clk); #1;
        tx_gap = 1;
        for (int i = 0; i < N; i++) push(i, 1, 8'h10 + 8'(i));
        expect_tx(4'b0001, 8'h10); expect_tx(4'b0010, 8'h11);
        expect_tx(4'b0100, 8'h12); expect_tx(4'b1000, 8'h13);
        wait_done("t2");

        // 3: requester 2 arrives while requester 1 is mid-packet
        @(posedge clk); #1;
        tx_gap = 2;
        push(1, 0, 8'h21); push(1, 0, 8'h22); push(1, 0, 8'h23); push(1, 1, 8'h24);
        for (int i = 0; i < 4; i++) expect_tx(4'b0010, 8'h21 + 8'(i));
        expect_tx(4'b0100, 8'h31); expect_tx(4'b0100, 8'h32);
        cnt = 0; k = 0;
        while (cnt < 2 && k < 200) begin
            @(negedge clk); k++;
            if (req_valid[1] && req_ready[1]) cnt++;
        end
        chk("t3_two_bytes", cnt, 2);
        @(posedge clk); #1;
        push(2, 0, 8'h31); push(2, 1, 8'h32);
        k = 0;
        while (k < 200) begin
            @(negedge clk); k++;
            if (grant == 4'b0010 && req_valid[2]) chk("t3_req2_stalled", req_ready[2], 0);
            if (req_valid[1] && req_ready[1] && req_last[1]) break;
        end
        chk("t3_last_seen", k < 200, 1);
        @(negedge clk);
        chk("t3_idle_busy", busy, 0);
        chk("t3_idle_grant", grant, 0);
        @(negedge clk);
        chk("t3_grant_req2", grant, 4'b0100);
        wait_done("t3");

        // 4: requester 0 stalls mid-packet, requester 3 pending
        do_reset();
        @(posedge clk); #1;
        tx_gap = 0;
        push(0, 0, 8'hA0); push(3, 1, 8'hB3);
        expect_tx(4'b0001, 8'hA0); expect_tx(4'b1000, 8'hB3);
        k = 0;
        while (!(req_valid[0] && req_ready[0]) && k < 200) begin
            @(negedge clk); k++;
        end
        chk("t4_first_byte", req_valid[0] && req_ready[0], 1);
        for (int c = 0; c <= 20; c++) begin
            @(negedge clk);
            chk($sformatf("t4_terr_c%0d", c), timeout_err, (c == 16) ? 4'b0001 : 4'b0000);
        end
        wait_done("t4");

        // 5: long transmitter back-pressure is not a timeout
        @(posedge clk); #1;
        tx_hold = 1'b1;
        push(0, 1, 8'h55);
        expect_tx(4'b0001, 8'h55);
        k = 0;
        while (!busy && k < 200) begin
            @(negedge clk); k++;
        end
        chk("t5_granted", grant, 4'b0001);
        bad = 0;
        repeat (1000) begin
            @(negedge clk);
            if (timeout_err != 0 || tx_data != 8'h55 || !tx_valid) bad++;
        end
        chk("t5_hold_stable", bad, 0);
        @(posedge clk); #1;
        tx_hold = 1'b0;
        @(negedge clk);
        chk("t5_first_xfer", tx_valid && tx_ready, 1);
        wait_done("t5");

        // 6: asynchronous reset mid-packet, then 1 and 2 request together
        @(posedge clk); #1;
        tx_gap = 6;
        push(2, 0, 8'hC0); push(2, 0, 8'hC1); push(2, 1, 8'hC2);
        expect_tx(4'b0100, 8'hC0);
        k = 0;
        while (!(req_valid[2] && req_ready[2]) && k < 200) begin
            @(negedge clk); k++;
        end
        chk("t6_first_byte", req_valid[2] && req_ready[2], 1);
        @(posedge clk); #3;
        chk("t6_pre_busy", busy, 1);
        rst_n = 1'b0;
        #1;
        chk("t6_rst_grant", grant, 0);
        chk("t6_rst_busy", busy, 0);
        chk("t6_rst_tx_valid", tx_valid, 0);
        chk("t6_rst_req_ready", req_ready, 0);
        rq[2].delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        tx_gap = 1;
        push(1, 1, 8'h61); push(2, 1, 8'h62);
        expect_tx(4'b0010, 8'h61); expect_tx(4'b0100, 8'h62);
        wait_done("t6");

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d passed so far", n_pass, n_tot);
        $fatal(1);
    end

endmodule
